// File: rtl/decoder_hold.sv
// decoder_hold: registered 3-to-8 decoder with valid/ready handshake,
// programmable hold time and guard gap.
//
// Parameters:
//   HOLD_CYCLES  cycles the one-hot select is driven per accepted code (1..255)
//   GAP_CYCLES   idle cycles after each hold before the next accept (0..255)
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-high reset
//   en     enable, active-low (0 = enabled); high in HOLD/GAP aborts
//   b      3-bit input code, latched on accept
//   valid  b is valid this cycle
//   ready  combinational: block can accept a code this cycle
//   d      registered one-hot select, zero when not holding
//   busy   registered, high in HOLD or GAP
//   done   registered one-cycle pulse on normal hold completion
module decoder_hold #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [2:0] b,
    input  logic       valid,
    output logic       ready,
    output logic [7:0] d,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] counter, counter_n;
    logic [7:0]       d_n;
    logic             done_n;
    logic             busy_n;

    // ready is gated by rst so nothing can be accepted while reset is held
    assign ready = (state == IDLE) && !en && !rst;

    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            counter <= '0;
            d       <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            counter <= counter_n;
            d       <= d_n;
            done    <= done_n;
            busy    <= busy_n;
        end
    end

    // next-state and next-output logic
    always_comb begin
        state_n   = state;
        counter_n = counter;
        d_n       = d;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (valid && ready) begin
                    d_n       = 8'b1 << b;
                    counter_n = HOLD_INIT;
                    state_n   = HOLD;
                end
            end
            HOLD: begin
                if (en) begin
                    // abort: drop select, skip the gap, no done pulse
                    d_n       = '0;
                    counter_n = '0;
                    state_n   = IDLE;
                end else if (counter != '0) begin
                    counter_n = counter - CNT_W'(1);
                end else begin
                    d_n    = '0;
                    done_n = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        state_n = IDLE;
                    end else begin
                        counter_n = GAP_INIT;
                        state_n   = GAP;
                    end
                end
            end
            GAP: begin
                d_n = '0;
                if (en) begin
                    counter_n = '0;
                    state_n   = IDLE;
                end else if (counter != '0) begin
                    counter_n = counter - CNT_W'(1);
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                d_n       = '0;
                counter_n = '0;
                state_n   = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_decoder_hold.sv
// Testbench for decoder_hold: table-driven per-cycle vectors for a
// HOLD=4/GAP=1 instance and a HOLD=1/GAP=0 instance, plus a code sweep
// and an asynchronous reset sequence.
module tb_decoder_hold;

    typedef struct {
        logic       en;
        logic       valid;
        logic [2:0] b;
        logic [7:0] d;
        logic       ready;
        logic       busy;
        logic       done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_a, valid_a, ready_a, busy_a, done_a;
    logic [2:0] b_a;
    logic [7:0] d_a;
    logic       en_b, valid_b, ready_b, busy_b, done_b;
    logic [2:0] b_b;
    logic [7:0] d_b;

    int errors = 0;
    int checks = 0;

    vec_t tab_a[25];
    vec_t tab_b[6];

    always #5 clk = ~clk;

    decoder_hold #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .en(en_a), .b(b_a), .valid(valid_a),
        .ready(ready_a), .d(d_a), .busy(busy_a), .done(done_a)
    );

    decoder_hold #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .b(b_b), .valid(valid_b),
        .ready(ready_b), .d(d_b), .busy(busy_b), .done(done_b)
    );

    function automatic vec_t mk(input logic en, input logic valid, input logic [2:0] b,
                                input logic [7:0] d, input logic ready,
                                input logic busy, input logic done);
        vec_t v;
        v.en = en; v.valid = valid; v.b = b;
        v.d = d; v.ready = ready; v.busy = busy; v.done = done;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // one cycle: drive inputs after the falling edge, then compare outputs
    task automatic apply(input vec_t v, input string nm, input int idx, input bit sel_b);
        @(negedge clk);
        if (sel_b) begin
            en_b = v.en; valid_b = v.valid; b_b = v.b;
        end else begin
            en_a = v.en; valid_a = v.valid; b_a = v.b;
        end
        #1;
        if (sel_b) begin
            chk($sformatf("%s[%0d].d", nm, idx), d_b, v.d);
            chk($sformatf("%s[%0d].ready", nm, idx), 8'(ready_b), 8'(v.ready));
            chk($sformatf("%s[%0d].busy", nm, idx), 8'(busy_b), 8'(v.busy));
            chk($sformatf("%s[%0d].done", nm, idx), 8'(done_b), 8'(v.done));
        end else begin
            chk($sformatf("%s[%0d].d", nm, idx), d_a, v.d);
            chk($sformatf("%s[%0d].ready", nm, idx), 8'(ready_a), 8'(v.ready));
            chk($sformatf("%s[%0d].busy", nm, idx), 8'(busy_a), 8'(v.busy));
            chk($sformatf("%s[%0d].done", nm, idx), 8'(done_a), 8'(v.done));
        end
    endtask

    initial begin
        // single code b=5, then b=1 with b=7 pending, then abort of b=3
        tab_a[0]  = mk(0, 1, 3'd5, 8'h00, 1, 0, 0);
        tab_a[1]  = mk(0, 0, 3'd0, 8'h20, 0, 1, 0);
        tab_a[2]  = mk(0, 0, 3'd0, 8'h20, 0, 1, 0);
        tab_a[3]  = mk(0, 0, 3'd0, 8'h20, 0, 1, 0);
        tab_a[4]  = mk(0, 0, 3'd0, 8'h20, 0, 1, 0);
        tab_a[5]  = mk(0, 0, 3'd0, 8'h00, 0, 1, 1);
        tab_a[6]  = mk(0, 1, 3'd1, 8'h00, 1, 0, 0);
        tab_a[7]  = mk(0, 1, 3'd7, 8'h02, 0, 1, 0);
        tab_a[8]  = mk(0, 1, 3'd7, 8'h02, 0, 1, 0);
        tab_a[9]  = mk(0, 1, 3'd7, 8'h02, 0, 1, 0);
        tab_a[10] = mk(0, 1, 3'd7, 8'h02, 0, 1, 0);
        tab_a[11] = mk(0, 1, 3'd7, 8'h00, 0, 1, 1);
        tab_a[12] = mk(0, 1, 3'd7, 8'h00, 1, 0, 0);
        tab_a[13] = mk(0, 0, 3'd0, 8'h80, 0, 1, 0);
        tab_a[14] = mk(0, 0, 3'd0, 8'h80, 0, 1, 0);
        tab_a[15] = mk(0, 0, 3'd0, 8'h80, 0, 1, 0);
        tab_a[16] = mk(0, 0, 3'd0, 8'h80, 0, 1, 0);
        tab_a[17] = mk(0, 0, 3'd0, 8'h00, 0, 1, 1);
        tab_a[18] = mk(0, 1, 3'd3, 8'h00, 1, 0, 0);
        tab_a[19] = mk(0, 0, 3'd0, 8'h08, 0, 1, 0);
        tab_a[20] = mk(1, 0, 3'd0, 8'h08, 0, 1, 0);
        tab_a[21] = mk(1, 0, 3'd0, 8'h00, 0, 0, 0);
        tab_a[22] = mk(1, 1, 3'd4, 8'h00, 0, 0, 0);
        tab_a[23] = mk(0, 0, 3'd0, 8'h00, 1, 0, 0);
        tab_a[24] = mk(0, 0, 3'd0, 8'h00, 1, 0, 0);

        // HOLD=1, GAP=0, continuous valid with b=2 then b=6
        tab_b[0] = mk(0, 1, 3'd2, 8'h00, 1, 0, 0);
        tab_b[1] = mk(0, 1, 3'd6, 8'h04, 0, 1, 0);
        tab_b[2] = mk(0, 1, 3'd6, 8'h00, 1, 0, 1);
        tab_b[3] = mk(0, 0, 3'd0, 8'h40, 0, 1, 0);
        tab_b[4] = mk(0, 0, 3'd0, 8'h00, 1, 0, 1);
        tab_b[5] = mk(0, 0, 3'd0, 8'h00, 1, 0, 0);

        rst = 1'b1;
        en_a = 1'b0; valid_a = 1'b0; b_a = 3'd0;
        en_b = 1'b0; valid_b = 1'b0; b_b = 3'd0;
        repeat (2) @(negedge clk);
        chk("rst_hold.ready", 8'(ready_a), 8'd0);
        rst = 1'b0;
        #1;
        chk("post_rst.d", d_a, 8'h00);
        chk("post_rst.busy", 8'(busy_a), 8'd0);
        chk("post_rst.done", 8'(done_a), 8'd0);
        chk("post_rst.ready", 8'(ready_a), 8'd1);

        for (int i = 0; i < 25; i++) apply(tab_a[i], "a", i, 1'b0);

        // sweep every code; valid stays high with a different code during hold
        for (int i = 0; i < 8; i++) begin
            logic [7:0] exp_d;
            exp_d = 8'b1 << i;
            apply(mk(0, 1, 3'(i), 8'h00, 1, 0, 0), $sformatf("sweep%0d", i), 0, 1'b0);
            for (int c = 1; c <= 4; c++)
                apply(mk(0, 1, 3'(~i), exp_d, 0, 1, 0), $sformatf("sweep%0d", i), c, 1'b0);
            apply(mk(0, 1, 3'(~i), 8'h00, 0, 1, 1), $sformatf("sweep%0d", i), 5, 1'b0);
        end
        apply(mk(0, 0, 3'd0, 8'h00, 1, 0, 0), "sweep_end", 0, 1'b0);

        // asynchronous reset in the middle of a hold of b=5
        apply(mk(0, 1, 3'd5, 8'h00, 1, 0, 0), "rst_seq", 0, 1'b0);
        apply(mk(0, 0, 3'd0, 8'h20, 0, 1, 0), "rst_seq", 1, 1'b0);
        apply(mk(0, 0, 3'd0, 8'h20, 0, 1, 0), "rst_seq", 2, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.d", d_a, 8'h00);
        chk("async_rst.busy", 8'(busy_a), 8'd0);
        chk("async_rst.done", 8'(done_a), 8'd0);
        chk("async_rst.ready", 8'(ready_a), 8'd0);
        valid_a = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_edge.ready", 8'(ready_a), 8'd0);
        chk("rst_edge.d", d_a, 8'h00);
        @(negedge clk);
        valid_a = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_release.ready", 8'(ready_a), 8'd1);
        chk("rst_release.d", d_a, 8'h00);

        for (int i = 0; i < 6; i++) apply(tab_b[i], "b", i, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decoder_hold.md
# decoder_hold

Registered 3-to-8 decoder with handshake and timed hold. It sits on the receive side of the 3-bit priority-code path and turns each accepted code back into a one-hot line select. The select is held for a programmable number of cycles, followed by a programmable guard gap. The block is the counterpart of the 8-to-3 priority encoder, and its enable uses the same active-low convention.

## Interface
Parameters:
- HOLD_CYCLES, default 4: cycles the one-hot output is driven per accepted code; legal range 1..255.
- GAP_CYCLES, default 1: idle cycles after each hold before the next code may be accepted; legal range 0..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  enable, active-low (0 = enabled).
- b  in  3  input code; selects output bit index b.
- valid  in  1  b is valid this cycle.
- ready  out  1  block can accept a code this cycle.
- d  out  8  registered one-hot output; all zero when not holding.
- busy  out  1  high in HOLD or GAP.
- done  out  1  one-cycle pulse on normal completion of a hold.

One clock; reset is asynchronous and active-high.

## Operation
- Reset values: d=8'b0, done=0, busy=0, state=IDLE, counter=0. ready=0 while rst is high.
- ready is combinational: (state==IDLE) && (en==0).
- Accept happens on a rising edge where valid && ready.
- FSM states:
  - IDLE. On accept: d <= 1<<b, counter <= HOLD_CYCLES-1, state <= HOLD. Inputs b and valid are ignored when not accepted.
  - HOLD. d is unchanged.
    - If counter != 0: counter decrements.
    - If counter == 0: d <= 0 and done <= 1. If GAP_CYCLES==0, state <= IDLE. Otherwise counter <= GAP_CYCLES-1 and state <= GAP.
  - GAP. d stays 0. Counter decrements; state <= IDLE when counter == 0.
- done is registered and high for exactly one cycle, then returns to 0.
- busy = (state != IDLE), registered with the state.
- Abort: if en==1 is sampled on any edge in HOLD or GAP, then d <= 0, state <= IDLE, counter <= 0, and done stays 0. The gap is skipped.
- Changes on b during HOLD do not affect d. The code is latched only at accept.
- The counter is 8 bits and never wraps below 0. The parameter range guarantees this.
- d is always one-hot or zero, and never has more than one bit set.

## Timing
- Latency: accept at edge k gives d valid in cycles k+1 through k+HOLD_CYCLES.
- At edge k+HOLD_CYCLES, d clears and done=1 for cycle k+HOLD_CYCLES+1.
- The state is IDLE, with ready=1 if en==0, from cycle k+HOLD_CYCLES+GAP_CYCLES+1.
- With GAP_CYCLES=0, ready rises in the same cycle as done, so back-to-back codes give d a one-cycle zero between selects.
- Throughput: one code per HOLD_CYCLES+GAP_CYCLES+1 cycles.
- rst asserted mid-operation clears all outputs immediately, without waiting for a clock edge. No done is produced.
- en deasserted (high) in IDLE drops ready combinationally in the same cycle.
- valid held high with ready low is ignored. No code is queued.

## Test plan
- Reset: assert rst mid-HOLD with d=8'b00100000 -> d=0, busy=0 and done=0 immediately, with no clock edge needed; ready=0 until rst falls.
- Single code with HOLD=4, GAP=1, en=0: b=3'd5 with valid for one cycle -> d=8'b00100000 for 4 cycles, then d=0 with done=1 for 1 cycle, then ready=1 on the 6th cycle after accept.
- Sweep: b=0..7 each accepted once -> d=8'b00000001, 00000010, ... 10000000 in order. Check no extra bits and no accepts while busy.
- Code change during HOLD: accept b=3'd1, then drive b=3'd7 with valid high -> d stays 8'b00000010 and the second code is accepted only once ready returns.
- Abort: accept b=3'd3, then raise en on the 2nd hold cycle -> d=0 on the next edge, done never asserts, state IDLE, ready=0 until en=0.
- GAP_CYCLES=0, HOLD_CYCLES=1, continuous valid with b=3'd2 then 3'd6 -> d is 00000100, 0, 01000000, 0, and done pulses once per code.
